// File: rtl/rtc_bus_responder_pkg.sv
// Shared definitions for the RTC bus responder: register map, BCD field limits,
// control bit positions and the calendar month-length lookup.
package rtc_bus_responder_pkg;

    localparam logic [7:0] ADDR_CTRL  = 8'h00;
    localparam logic [7:0] ADDR_SEC   = 8'h21;
    localparam logic [7:0] ADDR_MIN   = 8'h22;
    localparam logic [7:0] ADDR_HOUR  = 8'h23;
    localparam logic [7:0] ADDR_DAY   = 8'h24;
    localparam logic [7:0] ADDR_MONTH = 8'h25;
    localparam logic [7:0] ADDR_YEAR  = 8'h26;
    localparam logic [7:0] ADDR_WDAY  = 8'h27;
    localparam logic [7:0] ADDR_TSEC  = 8'h41;
    localparam logic [7:0] ADDR_TMIN  = 8'h42;
    localparam logic [7:0] ADDR_THOUR = 8'h43;

    localparam logic [7:0] BCD_00    = 8'h00;
    localparam logic [7:0] BCD_01    = 8'h01;
    localparam logic [7:0] SEC_MAX   = 8'h59;
    localparam logic [7:0] MIN_MAX   = 8'h59;
    localparam logic [7:0] HOUR_MAX  = 8'h23;
    localparam logic [7:0] MONTH_MAX = 8'h12;
    localparam logic [7:0] YEAR_MAX  = 8'h99;
    localparam logic [7:0] WDAY_MAX  = 8'h07;

    localparam int CTRL_RUN  = 0;
    localparam int CTRL_FLAG = 1;

    typedef struct packed {
        logic cs;
        logic a_d;
        logic rd;
        logic wr;
    } bus_sig_t;

    localparam bus_sig_t BUS_IDLE = '{cs: 1'b1, a_d: 1'b0, rd: 1'b1, wr: 1'b1};

    // Leap test works on the binary value of the BCD year; year 00 counts as leap.
    function automatic logic [7:0] month_days(input logic [7:0] month, input logic [7:0] year);
        logic [7:0] year_bin;
        logic [7:0] days;
        year_bin = {4'h0, year[7:4]} * 8'd10 + {4'h0, year[3:0]};
        case (month)
            8'h02:                      days = (year_bin[1:0] == 2'b00) ? 8'h29 : 8'h28;
            8'h04, 8'h06, 8'h09, 8'h11: days = 8'h30;
            default:                    days = 8'h31;
        endcase
        return days;
    endfunction

endpackage

// File: rtl/rtc_bus_responder_bcd_field_counter.sv
// One BCD register field: host load, count up with wrap/carry or count down
// with wrap/borrow. Out-of-range values wrap on the next step.
module bcd_field_counter #(
    parameter logic [7:0] RESET_VAL = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       up,
    input  logic       down,
    input  logic [7:0] min,
    input  logic [7:0] max,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic [7:0] value,
    output logic       co
);

    logic       at_max;
    logic       at_min;
    logic [7:0] inc;
    logic [7:0] dec;
    logic [7:0] nxt;

    assign at_max = value >= max;
    assign at_min = value <= min;
    assign co     = (up & at_max) | (down & at_min);

    always_comb begin
        inc = (value[3:0] >= 4'd9) ? {value[7:4] + 4'd1, 4'd0} : {value[7:4], value[3:0] + 4'd1};
        dec = (value[3:0] == 4'd0) ? {value[7:4] - 4'd1, 4'd9} : {value[7:4], value[3:0] - 4'd1};
        nxt = value;
        if (up) begin
            nxt = at_max ? min : inc;
        end else if (down) begin
            nxt = at_min ? max : dec;
        end
    end

    // A host load wins over a same-cycle count step; the carry above still fires.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            value <= RESET_VAL;
        end else if (load) begin
            value <= load_val;
        end else begin
            value <= nxt;
        end
    end

endmodule

// File: rtl/rtc_bus_responder.sv
// RTC chip model on the multiplexed 8-bit bus: synchronized strobe decoding,
// BCD calendar with ripple carry, countdown timer and registered read-back.
module rtc_bus_responder
    import rtc_bus_responder_pkg::*;
#(
    parameter int TICKS_PER_SEC = 100_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cs,
    input  logic       a_d,
    input  logic       rd,
    input  logic       wr,
    inout  wire  [7:0] dato,
    output logic       irq_n
);

    localparam int             PW      = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0]  PS_LAST = PW'(TICKS_PER_SEC - 1);

    bus_sig_t      s1, s2;
    logic          wr_d;
    logic          bus_wr, addr_wr, data_wr, drive;
    logic [7:0]    addr_q, rd_mux, rd_q;
    logic [PW-1:0] ps_cnt;
    logic          tick;
    logic          run, flag;
    logic [7:0]    sec_q, min_q, hour_q, day_q, month_q, year_q, wday_q;
    logic [7:0]    tsec_q, tmin_q, thour_q, day_max;
    logic          sec_co, min_co, hour_co, day_co, month_co, year_co, wday_co;
    logic          tsec_co, tmin_co, thour_co;
    logic          t_zero, t_last, t_step, expire;
    logic          unused_co;

    // Bus protocol: a write commits on the synchronized wr rising edge while cs is
    // low (a_d selects address vs data); dato is driven only while cs, rd are low,
    // a_d is high and wr is not low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1   <= BUS_IDLE;
            s2   <= BUS_IDLE;
            wr_d <= 1'b1;
        end else begin
            s1   <= '{cs: cs, a_d: a_d, rd: rd, wr: wr};
            s2   <= s1;
            wr_d <= s2.wr;
        end
    end

    assign bus_wr  = s2.wr & ~wr_d & ~s2.cs;
    assign addr_wr = bus_wr & ~s2.a_d;
    assign data_wr = bus_wr & s2.a_d;
    assign drive   = reset & ~s2.cs & s2.a_d & ~s2.rd & s2.wr;
    assign dato    = drive ? rd_q : 8'hzz;
    assign irq_n   = ~flag;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q <= 8'h00;
            ps_cnt <= '0;
            rd_q   <= 8'h00;
        end else begin
            if (addr_wr) addr_q <= dato;
            ps_cnt <= tick ? '0 : ps_cnt + 1'b1;
            rd_q   <= rd_mux;
        end
    end

    assign tick    = ps_cnt == PS_LAST;
    assign day_max = month_days(month_q, year_q);

    bcd_field_counter #(.RESET_VAL(8'h00)) u_sec (.clk(clk), .reset(reset), .up(tick), .down(1'b0),
        .min(BCD_00), .max(SEC_MAX), .load(data_wr && addr_q == ADDR_SEC), .load_val(dato), .value(sec_q), .co(sec_co));
    bcd_field_counter #(.RESET_VAL(8'h00)) u_min (.clk(clk), .reset(reset), .up(sec_co), .down(1'b0),
        .min(BCD_00), .max(MIN_MAX), .load(data_wr && addr_q == ADDR_MIN), .load_val(dato), .value(min_q), .co(min_co));
    bcd_field_counter #(.RESET_VAL(8'h00)) u_hour (.clk(clk), .reset(reset), .up(min_co), .down(1'b0),
        .min(BCD_00), .max(HOUR_MAX), .load(data_wr && addr_q == ADDR_HOUR), .load_val(dato), .value(hour_q), .co(hour_co));
    bcd_field_counter #(.RESET_VAL(8'h01)) u_day (.clk(clk), .reset(reset), .up(hour_co), .down(1'b0),
        .min(BCD_01), .max(day_max), .load(data_wr && addr_q == ADDR_DAY), .load_val(dato), .value(day_q), .co(day_co));
    bcd_field_counter #(.RESET_VAL(8'h01)) u_wday (.clk(clk), .reset(reset), .up(hour_co), .down(1'b0),
        .min(BCD_01), .max(WDAY_MAX), .load(data_wr && addr_q == ADDR_WDAY), .load_val(dato), .value(wday_q), .co(wday_co));
    bcd_field_counter #(.RESET_VAL(8'h01)) u_month (.clk(clk), .reset(reset), .up(day_co), .down(1'b0),
        .min(BCD_01), .max(MONTH_MAX), .load(data_wr && addr_q == ADDR_MONTH), .load_val(dato), .value(month_q), .co(month_co));
    bcd_field_counter #(.RESET_VAL(8'h00)) u_year (.clk(clk), .reset(reset), .up(month_co), .down(1'b0),
        .min(BCD_00), .max(YEAR_MAX), .load(data_wr && addr_q == ADDR_YEAR), .load_val(dato), .value(year_q), .co(year_co));

    // Timer stops on 00:00:00 instead of wrapping; the step that lands there expires it.
    assign t_zero = (tsec_q == 8'h00) && (tmin_q == 8'h00) && (thour_q == 8'h00);
    assign t_last = (tsec_q == 8'h01) && (tmin_q == 8'h00) && (thour_q == 8'h00);
    assign t_step = tick & run;
    assign expire = t_step & (t_zero | t_last);

    bcd_field_counter #(.RESET_VAL(8'h00)) u_tsec (.clk(clk), .reset(reset), .up(1'b0), .down(t_step & ~t_zero),
        .min(BCD_00), .max(SEC_MAX), .load(data_wr && addr_q == ADDR_TSEC), .load_val(dato), .value(tsec_q), .co(tsec_co));
    bcd_field_counter #(.RESET_VAL(8'h00)) u_tmin (.clk(clk), .reset(reset), .up(1'b0), .down(tsec_co),
        .min(BCD_00), .max(MIN_MAX), .load(data_wr && addr_q == ADDR_TMIN), .load_val(dato), .value(tmin_q), .co(tmin_co));
    bcd_field_counter #(.RESET_VAL(8'h00)) u_thour (.clk(clk), .reset(reset), .up(1'b0), .down(tmin_co),
        .min(BCD_00), .max(HOUR_MAX), .load(data_wr && addr_q == ADDR_THOUR), .load_val(dato), .value(thour_q), .co(thour_co));

    assign unused_co = year_co | wday_co | thour_co;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run  <= 1'b0;
            flag <= 1'b0;
        end else begin
            if (expire) begin
                run  <= 1'b0;
                flag <= 1'b1;
            end
            if (data_wr && addr_q == ADDR_CTRL) begin
                run <= dato[CTRL_RUN];
                if (dato[CTRL_FLAG]) flag <= 1'b0;
            end
        end
    end

    always_comb begin
        rd_mux = 8'h00;
        case (addr_q)
            ADDR_CTRL:  rd_mux = {6'b0, flag, run};
            ADDR_SEC:   rd_mux = sec_q;
            ADDR_MIN:   rd_mux = min_q;
            ADDR_HOUR:  rd_mux = hour_q;
            ADDR_DAY:   rd_mux = day_q;
            ADDR_MONTH: rd_mux = month_q;
            ADDR_YEAR:  rd_mux = year_q;
            ADDR_WDAY:  rd_mux = wday_q;
            ADDR_TSEC:  rd_mux = tsec_q;
            ADDR_TMIN:  rd_mux = tmin_q;
            ADDR_THOUR: rd_mux = thour_q;
            default:    rd_mux = 8'h00;
        endcase
    end

endmodule
